// File: rtl/rx_receiver.sv
// rx_receiver: 1-tap DFE slicer, electrical-idle detect with hysteresis and deserializer.
// Define DFE_ADAPT_EN for sign-sign tap adaptation with the dfe_tap_out port.
module rx_receiver #(
  parameter real EIDLE_THRESH_V  = 0.065,
  parameter int  EIDLE_EXIT_CNT  = 8,
  parameter int  EIDLE_ENTRY_CNT = 16,
  parameter int  DESER_WIDTH     = 10,
  parameter real DFE_TAP_MAX_V   = 0.1
) (
  input  logic                   bit_clk,
  input  logic                   reset,
  input  logic                   vdd,
  input  logic                   vss,
  input  logic                   rx_en,
  input  real                    rx_dp,
  input  real                    rx_dn,
  input  logic [5:0]             dfe_tap,
  output logic                   bit_out,
  output logic [DESER_WIDTH-1:0] par_data,
  output logic                   par_valid,
  output logic                   signal_det,
  output logic                   eidle
`ifdef DFE_ADAPT_EN
  ,
  output logic [5:0]             dfe_tap_out
`endif
);
  localparam int CMAX = EIDLE_ENTRY_CNT > EIDLE_EXIT_CNT ? EIDLE_ENTRY_CNT : EIDLE_EXIT_CNT;
  localparam int CW = $clog2(CMAX);
  localparam int BW = $clog2(DESER_WIDTH);
  typedef enum logic [1:0] {IDLE, DETECT, ACTIVE, LOSS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [DESER_WIDTH-2:0] sreg;
  logic prev_bit, slice, above, drop, lock;
  logic [5:0] tap_code;
  real diff, tap_v, eq;
  logic unused_supply;
  assign unused_supply = vdd ^ vss;
`ifdef DFE_ADAPT_EN
  real err;
  logic up;
  assign tap_code = dfe_tap_out;
`else
  assign tap_code = dfe_tap;
`endif
  always_comb begin
    diff = rx_dp - rx_dn;
    tap_v = real'(tap_code) * DFE_TAP_MAX_V / 63.0;
    eq = diff - (prev_bit ? tap_v : -tap_v);
    slice = eq >= 0.0;
    above = (diff < 0.0 ? -diff : diff) >= EIDLE_THRESH_V;
    lock = state == DETECT && above && cnt == CW'(EIDLE_EXIT_CNT - 1);
    drop = state == LOSS && !above && cnt == CW'(EIDLE_ENTRY_CNT - 1);
  end
  always_ff @(posedge bit_clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sreg <= '0;
      prev_bit <= 1'b0;
      bit_out <= 1'b0;
      par_data <= '0;
      par_valid <= 1'b0;
      signal_det <= 1'b0;
      eidle <= 1'b1;
    end else if (!rx_en) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sreg <= '0;
      prev_bit <= 1'b0;
      bit_out <= 1'b0;
      par_data <= '0;
      par_valid <= 1'b0;
      signal_det <= 1'b0;
      eidle <= 1'b1;
    end else begin
      bit_out <= slice;
      prev_bit <= slice;
      par_valid <= 1'b0;
      // the edge that falls back to IDLE discards the word in progress
      if ((state == ACTIVE || state == LOSS) && !drop) begin
        if (bcnt == BW'(DESER_WIDTH - 1)) begin
          par_data <= {slice, sreg};
          par_valid <= 1'b1;
          bcnt <= '0;
        end else begin
          sreg[bcnt] <= slice;
          bcnt <= bcnt + 1'b1;
        end
      end
      case (state)
        IDLE: if (above) begin
          state <= DETECT;
          cnt <= CW'(1);
        end
        DETECT: if (!above) begin
          state <= IDLE;
          cnt <= '0;
        end else if (lock) begin
          state <= ACTIVE;
          cnt <= '0;
          bcnt <= '0;
          signal_det <= 1'b1;
          eidle <= 1'b0;
        end else cnt <= cnt + 1'b1;
        ACTIVE: if (!above) begin
          state <= LOSS;
          cnt <= CW'(1);
        end
        LOSS: if (above) begin
          state <= ACTIVE;
          cnt <= '0;
        end else if (drop) begin
          state <= IDLE;
          cnt <= '0;
          bcnt <= '0;
          signal_det <= 1'b0;
          eidle <= 1'b1;
        end else cnt <= cnt + 1'b1;
      endcase
    end
`ifdef DFE_ADAPT_EN
  // sign-sign LMS against a +/-0.2 V target
  always_comb begin
    err = eq - (slice ? 0.2 : -0.2);
    up = (err >= 0.0) == prev_bit;
  end
  always_ff @(posedge bit_clk or negedge reset)
    if (!reset) dfe_tap_out <= '0;
    else if (!rx_en) dfe_tap_out <= '0;
    else if (lock) dfe_tap_out <= dfe_tap;
    else if (state == ACTIVE)
      dfe_tap_out <= up ? (dfe_tap_out == 6'd63 ? dfe_tap_out : dfe_tap_out + 1'b1)
                        : (dfe_tap_out == 6'd0 ? dfe_tap_out : dfe_tap_out - 1'b1);
`endif
endmodule

// File: tb/tb_rx_receiver.sv
// tb_rx_receiver: directed and randomized checks of rx_receiver against a run-length reference model.
module tb_rx_receiver;
  logic bit_clk = 1'b0, reset = 1'b0, vdd = 1'b1, vss = 1'b0, rx_en = 1'b0;
  real rx_dp = 0.0, rx_dn = 0.0;
  logic [5:0] dfe_tap = '0;
  logic bit_out, par_valid, signal_det, eidle;
  logic [9:0] par_data;
  int checks = 0, errors = 0;
  logic m_prev, m_bit, m_present, m_valid;
  logic [9:0] m_data;
  int m_run;
  logic m_q[$];
  real idle_v[4] = '{0.0, 0.02, 0.03, 0.05};
  real act_v[3] = '{0.15, 0.4, 0.4};
  logic pat[10] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 1};

  rx_receiver dut (
    .bit_clk(bit_clk), .reset(reset), .vdd(vdd), .vss(vss), .rx_en(rx_en),
    .rx_dp(rx_dp), .rx_dn(rx_dn), .dfe_tap(dfe_tap), .bit_out(bit_out),
    .par_data(par_data), .par_valid(par_valid), .signal_det(signal_det), .eidle(eidle)
  );

  always #5 bit_clk = ~bit_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_bit = 0; m_present = 0; m_valid = 0; m_data = '0; m_run = 0;
    m_q.delete();
  endtask

  // signal presence tracked as run lengths of above/below-threshold cycles
  task automatic model_step(input real v, input logic [5:0] tap);
    real tv, eq;
    logic b, ab;
    tv = real'(tap) * 0.1 / 63.0;
    eq = v - (m_prev ? tv : -tv);
    b = eq >= 0.0;
    ab = (v < 0.0 ? -v : v) >= 0.065;
    m_valid = 0;
    if (!m_present) begin
      m_run = ab ? m_run + 1 : 0;
      if (m_run == 8) begin m_present = 1; m_run = 0; m_q.delete(); end
    end else begin
      m_run = ab ? 0 : m_run + 1;
      if (m_run == 16) begin
        m_present = 0; m_run = 0; m_q.delete();
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 10) begin
          for (int i = 0; i < 10; i++) m_data[i] = m_q[i];
          m_valid = 1;
          m_q.delete();
        end
      end
    end
    m_prev = b;
    m_bit = b;
  endtask

  task automatic compare_all();
    check("bit_out", 32'(bit_out), 32'(m_bit));
    check("signal_det", 32'(signal_det), 32'(m_present));
    check("eidle", 32'(eidle), 32'(!m_present));
    check("par_valid", 32'(par_valid), 32'(m_valid));
    check("par_data", 32'(par_data), 32'(m_data));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    check({tag, "_par_data"}, 32'(par_data), 32'd0);
    check({tag, "_par_valid"}, 32'(par_valid), 32'd0);
    check({tag, "_signal_det"}, 32'(signal_det), 32'd0);
    check({tag, "_eidle"}, 32'(eidle), 32'd1);
  endtask

  task automatic step(input real v, input logic [5:0] tap, input logic en);
    @(negedge bit_clk);
    rx_dp = v / 2.0;
    rx_dn = -v / 2.0;
    dfe_tap = tap;
    rx_en = en;
    if (!en) model_reset();
    else model_step(v, tap);
    @(posedge bit_clk);
    #1 compare_all();
  endtask

  initial begin
    real v;
    int mode, left;
    model_reset();
    rx_dp = 0.2; rx_dn = -0.2; rx_en = 1'b1;
    repeat (3) @(posedge bit_clk);
    #1 check_reset_vals("rst_hold");
    #2 reset = 1'b1;
    repeat (7) step(0.4, 6'd0, 1'b1);
    check("exit7_det", 32'(signal_det), 32'd0);
    step(0.4, 6'd0, 1'b1);
    check("exit8_det", 32'(signal_det), 32'd1);
    check("exit8_eidle", 32'(eidle), 32'd0);
    step(0.4, 6'd0, 1'b0);
    repeat (4) step(0.4, 6'd0, 1'b1);
    step(0.0, 6'd0, 1'b1);
    repeat (7) step(0.4, 6'd0, 1'b1);
    check("restart7_det", 32'(signal_det), 32'd0);
    step(0.4, 6'd0, 1'b1);
    check("restart8_det", 32'(signal_det), 32'd1);
    for (int i = 0; i < 10; i++) step(pat[i] ? 0.4 : -0.4, 6'd0, 1'b1);
    check("word_valid", 32'(par_valid), 32'd1);
    check("word_data", 32'(par_data), 32'b1100001101);
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1) ? 0.4 : -0.4, 6'd0, 1'b1);
      check("word_period", 32'(par_valid), 32'(i % 10 == 9));
    end
    step(0.4, 6'd0, 1'b1);
    step(0.05, 6'd63, 1'b1);
    check("dfe_tap63_p1", 32'(bit_out), 32'd0);
    step(0.4, 6'd0, 1'b1);
    step(0.05, 6'd0, 1'b1);
    check("dfe_tap0_p1", 32'(bit_out), 32'd1);
    step(-0.4, 6'd0, 1'b1);
    step(-0.05, 6'd63, 1'b1);
    check("dfe_tap63_p0", 32'(bit_out), 32'd1);
    step(0.4, 6'd0, 1'b1);
    repeat (15) step(0.0, 6'd0, 1'b1);
    step(0.4, 6'd0, 1'b1);
    check("loss_recover_det", 32'(signal_det), 32'd1);
    repeat (15) step(0.0, 6'd0, 1'b1);
    check("entry15_det", 32'(signal_det), 32'd1);
    step(0.0, 6'd0, 1'b1);
    check("entry16_det", 32'(signal_det), 32'd0);
    check("entry16_eidle", 32'(eidle), 32'd1);
    check("entry16_no_strobe", 32'(par_valid), 32'd0);
    repeat (8) step(0.4, 6'd0, 1'b1);
    repeat (4) step($urandom_range(0, 1) ? 0.4 : -0.4, 6'd0, 1'b1);
    step(0.4, 6'd0, 1'b0);
    check_reset_vals("en_drop");
    repeat (8) step(0.4, 6'd0, 1'b1);
    repeat (13) step($urandom_range(0, 1) ? 0.4 : -0.4, 6'd0, 1'b1);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge bit_clk);
    #2 reset = 1'b1;
    mode = 0;
    left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (left == 0) begin
        mode = $urandom_range(0, 2);
        left = $urandom_range(1, 40);
      end
      left--;
      v = mode == 0 ? act_v[$urandom_range(0, 2)] :
          mode == 1 ? idle_v[$urandom_range(0, 3)] :
          ($urandom_range(0, 1) ? act_v[$urandom_range(0, 2)] : idle_v[$urandom_range(0, 3)]);
      if ($urandom_range(0, 1) == 1) v = -v;
      step(v, 6'($urandom_range(0, 63)), $urandom_range(0, 299) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_receiver.md
Name: rx_receiver

Overview:
- Receive-side counterpart of the team's FFE transmit driver.
- Takes the real-valued differential pad pair rx_dp/rx_dn and applies a 1-tap decision-feedback equalizer (DFE) to cancel post-cursor ISI.
- Slices one bit per bit_clk, detects electrical idle (EI) by amplitude with entry/exit hysteresis, and deserializes the bit stream into DESER_WIDTH-bit words for the PCS.

Parameters:
- EIDLE_THRESH_V, 0.065: |rx_dp-rx_dn| below this (volts, real) counts as an idle cycle.
- EIDLE_EXIT_CNT, 8: consecutive above-threshold cycles needed to declare signal present.
- EIDLE_ENTRY_CNT, 16: consecutive below-threshold cycles needed to declare idle.
- DESER_WIDTH, 10: parallel word width.
- DFE_TAP_MAX_V, 0.100000: tap voltage at code 63; tap_v = code*DFE_TAP_MAX_V/63.

Ports:
- bit_clk  input  1  bit-rate clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low.
- vdd  input  1  supply pin, no functional effect.
- vss  input  1  supply pin, no functional effect.
- rx_en  input  1  receiver enable.
- rx_dp  input  real  positive pad voltage.
- rx_dn  input  real  negative pad voltage.
- dfe_tap  input  6  H1 DFE tap code.
- bit_out  output  1  registered sliced bit.
- par_data  output  DESER_WIDTH  deserialized word; bit 0 is the earliest received bit.
- par_valid  output  1  one-cycle strobe, par_data valid.
- signal_det  output  1  high while in ACTIVE or LOSS.
- eidle  output  1  high while in IDLE or DETECT.

Behaviour:
- Reset (async, active-low):
  - bit_out=0, par_data=0, par_valid=0, signal_det=0, eidle=1.
  - prev_bit=0, state=IDLE, all counters=0, shift register=0.
- rx_en=0 at a posedge: synchronous return to the reset values above. Takes priority over every other event.
- Equalization (combinational, real arithmetic):
  - diff = rx_dp - rx_dn.
  - eq = diff - (prev_bit ? tap_v : -tap_v).
- Decision at each posedge: bit = (eq >= 0.0); exactly 0.0 slices to 1. bit_out<=bit, prev_bit<=bit.
  - The slicer runs in every state; latency is 1 cycle from the pad value to bit_out.
- Amplitude check at each posedge: above = (|diff| >= EIDLE_THRESH_V).
- FSM, one counter cnt:
  - IDLE: if above, cnt<=1 and go to DETECT.
  - DETECT: if !above, cnt<=0 and go to IDLE. If above and cnt==EIDLE_EXIT_CNT-1, go to ACTIVE with cnt<=0, bit counter<=0. Otherwise cnt++.
  - ACTIVE: if !above, cnt<=1 and go to LOSS.
  - LOSS: if above, cnt<=0 and go to ACTIVE. If !above and cnt==EIDLE_ENTRY_CNT-1, go to IDLE with cnt<=0, and discard the partial word (no par_valid). Otherwise cnt++.
- Outputs signal_det and eidle are registered and update on the same edge as the state change.
- Deserializer runs only in ACTIVE and LOSS, including on the edge where LOSS→ACTIVE is taken:
  - The bit sliced on the edge is written into shift position bcnt; then bcnt++.
  - When bcnt==DESER_WIDTH-1, par_data<=complete word, par_valid<=1 for one cycle, bcnt<=0.
  - The first bit of the first word is the bit sliced on the first edge spent in ACTIVE.
- par_valid is 0 in every other cycle. par_data holds its value between strobes.
- Changes on dfe_tap take effect on the next decision. There is no internal tap storage.

Optional Feature:
- Macro: DFE_ADAPT_EN.
- With the macro defined:
  - An internal 6-bit tap register replaces dfe_tap in the tap_v computation.
  - The register loads dfe_tap on every DETECT→ACTIVE edge.
  - In ACTIVE, on each decision: err = eq - (bit ? 0.2 : -0.2). If sign(err) equals the sign of the prev_bit symbol (1→+, 0→-), tap++; otherwise tap--.
  - The tap saturates at 0 and 63.
  - Extra output dfe_tap_out (6 bits) exposes the register; reset value 0.
- Without the macro: tap_v comes from dfe_tap directly and the dfe_tap_out port does not exist.

Test Plan:
- Reset check: hold reset=0 while driving rx_dp=0.2, rx_dn=-0.2 → eidle=1, signal_det=0, par_valid=0, bit_out=0.
- Idle exit: rx_en=1, |diff|=0.4 for 8 cycles → signal_det rises on the 8th edge, eidle falls on the same edge. Repeat with a single idle cycle at cycle 5 → the count restarts and detection takes 8 further cycles.
- Word assembly: after ACTIVE, drive the pattern 1,0,1,1,0,0,0,0,1,1 with diff=±0.4 → par_valid pulses once with par_data=10'b1100001101, then pulses again every 10 cycles.
- DFE correction: dfe_tap=63 (tap_v=0.1), prev_bit=1, diff=+0.05 → bit=0. With dfe_tap=0 and the same diff → bit=1.
- Idle entry with hysteresis: in ACTIVE, 15 idle cycles then 1 active cycle → stays in signal_det=1. Then 16 idle cycles → IDLE on the 16th edge and the partial word is never strobed.
- Enable and reset mid-operation: drop rx_en mid-word, and separately assert async reset mid-word → all outputs return to reset values at once, with no par_valid pulse.
